skeeball_game_ctrl: RTL and testbench



---
 rtl/skeeball_pkg.sv | 19 +
 rtl/skeeball_edge_detect.sv | 18 +
 rtl/skeeball_game_ctrl.sv | 137 +++++++++++++
 tb/tb_skeeball_game_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/skeeball_pkg.sv
// Shared types and helpers for the skeeball game controller family.
package skeeball_pkg;

    typedef enum logic [1:0] {
        ST_MENU  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_FIN   = 2'b10,
        ST_SCORE = 2'b11
    } state_t;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/skeeball_edge_detect.sv
// Rising-edge detector; history resets high so a level held through reset is not an edge.
module skeeball_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_q <= 1'b1;
        else        level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/skeeball_game_ctrl.sv
// Skeeball game sequencer: menu, play with ball counting and scoring, finish, last-score display.
module skeeball_game_ctrl
    import skeeball_pkg::*;
#(
    parameter int BALLS       = 9,
    parameter int PTS_W       = 7,
    parameter int SCORE_W     = 10,
    parameter int IDLE_CYC    = 50000000,
    parameter int FINISH_CYC  = 25000000,
    parameter int DISPLAY_CYC = 250000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_btn,
    input  logic                         ball_valid,
    input  logic [PTS_W-1:0]             ball_pts,
    output logic [1:0]                   state,
    output logic                         menu_st,
    output logic                         play_st,
    output logic                         fin_st,
    output logic                         score_st,
    output logic [SCORE_W-1:0]           score,
    output logic [clog2(BALLS+1)-1:0]    balls_left,
    output logic [SCORE_W-1:0]           last_score,
    output logic [SCORE_W-1:0]           high_score,
    output logic                         new_high
);

    localparam int BL_W    = clog2(BALLS + 1);
    localparam int MAX_A   = (IDLE_CYC > FINISH_CYC) ? IDLE_CYC : FINISH_CYC;
    localparam int MAX_CYC = (MAX_A > DISPLAY_CYC) ? MAX_A : DISPLAY_CYC;
    localparam int TMR_W   = (clog2(MAX_CYC) < 1) ? 1 : clog2(MAX_CYC);
    localparam int SUM_W   = ((SCORE_W > PTS_W) ? SCORE_W : PTS_W) + 1;

    localparam logic [SCORE_W-1:0] SMAX      = '1;
    localparam logic [TMR_W-1:0]   IDLE_LAST = TMR_W'(IDLE_CYC - 1);
    localparam logic [TMR_W-1:0]   FIN_LAST  = TMR_W'(FINISH_CYC - 1);
    localparam logic [TMR_W-1:0]   DISP_LAST = TMR_W'(DISPLAY_CYC - 1);

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [SCORE_W-1:0]  score_q, score_d, last_q, last_d, high_q, high_d;
    logic [BL_W-1:0]     balls_q, balls_d;
    logic                new_high_q, new_high_d;
    logic                start_edge, fin_entry;
    logic [SUM_W-1:0]    sum;

    skeeball_edge_detect u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (start_btn),
        .rise  (start_edge)
    );

    assign sum = SUM_W'(score_q) + SUM_W'(ball_pts);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_MENU;
            timer_q    <= '0;
            score_q    <= '0;
            balls_q    <= BL_W'(BALLS);
            last_q     <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            score_q    <= score_d;
            balls_q    <= balls_d;
            last_q     <= last_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + TMR_W'(1);
        score_d    = score_q;
        balls_d    = balls_q;
        last_d     = last_q;
        high_d     = high_q;
        new_high_d = 1'b0;
        fin_entry  = 1'b0;
        case (state_q)
            ST_MENU: begin
                timer_d = '0;
                if (start_edge) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                    balls_d = BL_W'(BALLS);
                end
            end
            ST_PLAY: begin
                // A ball in the same cycle as idle expiry takes priority.
                if (ball_valid) begin
                    score_d = (sum > SUM_W'(SMAX)) ? SMAX : sum[SCORE_W-1:0];
                    balls_d = balls_q - BL_W'(1);
                    timer_d = '0;
                    if (balls_q == BL_W'(1)) fin_entry = 1'b1;
                end else if (timer_q == IDLE_LAST) begin
                    fin_entry = 1'b1;
                end
                if (fin_entry) state_d = ST_FIN;
            end
            ST_FIN: begin
                if (timer_q == FIN_LAST) state_d = ST_SCORE;
            end
            ST_SCORE: begin
                if (start_edge || timer_q == DISP_LAST) state_d = ST_MENU;
            end
            default: state_d = ST_MENU;
        endcase
        if (state_d != state_q) timer_d = '0;
        // Final score is captured on the edge that enters FINISH.
        if (fin_entry) begin
            last_d = score_d;
            if (score_d > high_q) begin
                high_d     = score_d;
                new_high_d = 1'b1;
            end
        end
    end

    assign state      = state_q;
    assign menu_st    = (state_q == ST_MENU);
    assign play_st    = (state_q == ST_PLAY);
    assign fin_st     = (state_q == ST_FIN);
    assign score_st   = (state_q == ST_SCORE);
    assign score      = score_q;
    assign balls_left = balls_q;
    assign last_score = last_q;
    assign high_score = high_q;
    assign new_high   = new_high_q;

endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// Bench for skeeball_game_ctrl: directed games with literal expectations, then random play vs a phase model.
module tb_skeeball_game_ctrl;

    localparam int BALLS = 3, PTS_W = 7, SCORE_W = 8;
    localparam int IDLE = 20, FIN = 4, DISP = 8;
    localparam int SMAX = (1 << SCORE_W) - 1;

    logic clk = 1'b0;
    logic rst_n, start_btn, ball_valid;
    logic [PTS_W-1:0] ball_pts;
    logic [1:0] state;
    logic menu_st, play_st, fin_st, score_st, new_high;
    logic [SCORE_W-1:0] score, last_score, high_score;
    logic [1:0] balls_left;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    skeeball_game_ctrl #(
        .BALLS(BALLS), .PTS_W(PTS_W), .SCORE_W(SCORE_W),
        .IDLE_CYC(IDLE), .FINISH_CYC(FIN), .DISPLAY_CYC(DISP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn),
        .ball_valid(ball_valid), .ball_pts(ball_pts),
        .state(state), .menu_st(menu_st), .play_st(play_st),
        .fin_st(fin_st), .score_st(score_st), .score(score),
        .balls_left(balls_left), .last_score(last_score),
        .high_score(high_score), .new_high(new_high)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Phase model: 0 menu, 1 playing, 2 finish, 3 last score; cnt = cycles remaining in the phase.
    int m_phase, m_cnt, m_score, m_balls, m_last, m_high;
    bit m_nh, m_prev;

    task automatic m_finish();
        m_phase = 2;
        m_cnt   = FIN;
        m_last  = m_score;
        if (m_score > m_high) begin
            m_high = m_score;
            m_nh   = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_cnt = 0; m_score = 0; m_balls = BALLS;
            m_last = 0; m_high = 0; m_nh = 0; m_prev = 1;
        end else begin
            bit se;
            se = start_btn && !m_prev;
            m_prev = start_btn;
            m_nh = 0;
            case (m_phase)
                0: if (se) begin
                    m_phase = 1; m_score = 0; m_balls = BALLS; m_cnt = IDLE;
                end
                1: if (ball_valid) begin
                    m_score = (m_score + int'(ball_pts) > SMAX) ? SMAX : m_score + int'(ball_pts);
                    m_balls = m_balls - 1;
                    m_cnt = IDLE;
                    if (m_balls == 0) m_finish();
                end else begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) m_finish();
                end
                2: begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin m_phase = 3; m_cnt = DISP; end
                end
                default: if (se) m_phase = 0;
                    else begin
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) m_phase = 0;
                    end
            endcase
        end
    end

    always @(negedge clk) begin
        check("state", int'(state), m_phase);
        check("flags", int'({menu_st, play_st, fin_st, score_st}), 8 >> m_phase);
        check("score", int'(score), m_score);
        check("balls_left", int'(balls_left), m_balls);
        check("last_score", int'(last_score), m_last);
        check("high_score", int'(high_score), m_high);
        check("new_high", int'(new_high), int'(m_nh));
    end

    // Literal expectation applied to both the DUT and the model.
    task automatic pin(input string name, input int dut_v, input int mdl_v, input int exp);
        check(name, dut_v, exp);
        check({name, "_model"}, mdl_v, exp);
    endtask

    task automatic press();
        start_btn = 1'b0;
        @(negedge clk);
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
    endtask

    task automatic ball(input int pts);
        ball_valid = 1'b1;
        ball_pts   = PTS_W'(pts);
        @(negedge clk);
        ball_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_btn = 1'b1; ball_valid = 1'b0; ball_pts = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        pin("held_btn_menu", int'(state), m_phase, 0);
        press();
        pin("start_play", int'(state), m_phase, 1);
        pin("start_balls", int'(balls_left), m_balls, 3);

        // Normal game
        ball(10);  pin("g1_score1", int'(score), m_score, 10);  pin("g1_balls1", int'(balls_left), m_balls, 2);
        ball(40);  pin("g1_score2", int'(score), m_score, 50);  pin("g1_balls2", int'(balls_left), m_balls, 1);
        ball(100); pin("g1_score3", int'(score), m_score, 150); pin("g1_balls3", int'(balls_left), m_balls, 0);
        pin("g1_fin", int'(state), m_phase, 2);
        pin("g1_last", int'(last_score), m_last, 150);
        pin("g1_high", int'(high_score), m_high, 150);
        pin("g1_nh_on", int'(new_high), int'(m_nh), 1);
        @(negedge clk);
        pin("g1_nh_off", int'(new_high), int'(m_nh), 0);
        repeat (2) @(negedge clk);
        pin("g1_fin_hold", int'(state), m_phase, 2);
        @(negedge clk);
        pin("g1_lastsc", int'(state), m_phase, 3);
        repeat (7) @(negedge clk);
        pin("g1_disp_hold", int'(state), m_phase, 3);
        @(negedge clk);
        pin("g1_menu", int'(state), m_phase, 0);

        // Ball in MENU ignored, start edge in PLAYING ignored, then idle timeout
        ball(50);
        pin("menu_ball_ign", int'(score), m_score, 150);
        press();
        press();
        pin("play_start_ign", int'(state), m_phase, 1);
        pin("play_start_balls", int'(balls_left), m_balls, 3);
        ball(30);
        repeat (19) @(negedge clk);
        pin("idle_hold", int'(state), m_phase, 1);
        @(negedge clk);
        pin("idle_fin", int'(state), m_phase, 2);
        pin("idle_balls", int'(balls_left), m_balls, 2);
        pin("idle_last", int'(last_score), m_last, 30);
        pin("idle_nh", int'(new_high), int'(m_nh), 0);
        press();
        ball(5);
        pin("fin_ign_state", int'(state), m_phase, 2);
        pin("fin_ign_score", int'(score), m_score, 30);
        @(negedge clk);
        pin("idle_lastsc", int'(state), m_phase, 3);
        press();
        pin("lastsc_start", int'(state), m_phase, 0);

        // Saturation
        press();
        ball(100); pin("sat1", int'(score), m_score, 100);
        ball(100); pin("sat2", int'(score), m_score, 200);
        ball(100); pin("sat3", int'(score), m_score, 255);
        pin("sat_last", int'(last_score), m_last, 255);
        pin("sat_high", int'(high_score), m_high, 255);
        repeat (30) @(negedge clk);

        // Random play
        for (int i = 0; i < 3000; i++) begin
            ball_valid = ($urandom_range(0, 3) == 0);
            ball_pts   = PTS_W'($urandom_range(0, 127));
            if ($urandom_range(0, 5) == 0) start_btn = ~start_btn;
            @(negedge clk);
        end
        ball_valid = 1'b0; start_btn = 1'b0;
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-game
        press();
        ball(20);
        #3 rst_n = 1'b0;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_score", int'(score), 0);
        check("rst_balls", int'(balls_left), 3);
        check("rst_last", int'(last_score), 0);
        check("rst_high", int'(high_score), 0);
        check("rst_nh", int'(new_high), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
